// File: rtl/fetch_pipe_if.sv
// Fetch-stage bus: next-PC select, execute-stage targets, hazard controls,
// instruction-memory handshake and the IF/ID register outputs.
interface fetch_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       SEL_DIR;
  logic [WIDTH-1:0] DOA_exe;
  logic [WIDTH-1:0] jump_exe;
  logic [WIDTH-1:0] branch_exe;
  logic             stall;
  logic             flush;
  logic             mem_ready;
  logic [31:0]      INSTR;
  logic [WIDTH-1:0] OUT_REG1;
  logic [3:0]       PC_4;
  logic [31:0]      IFID_instr;
  logic [WIDTH-1:0] IFID_pc4;
  logic             IFID_valid;
  logic             misalign;

  // Driver side: hazard unit, execute stage and instruction memory.
  modport master (
    output SEL_DIR, DOA_exe, jump_exe, branch_exe, stall, flush, mem_ready, INSTR,
    input  OUT_REG1, PC_4, IFID_instr, IFID_pc4, IFID_valid, misalign
  );

  // Fetch stage side.
  modport slave (
    input  SEL_DIR, DOA_exe, jump_exe, branch_exe, stall, flush, mem_ready, INSTR,
    output OUT_REG1, PC_4, IFID_instr, IFID_pc4, IFID_valid, misalign
  );
endinterface

// File: rtl/fetch_pipe.sv
// Instruction-fetch stage: program counter with four next-PC sources,
// IF/ID capture register with valid bit, stall/flush/memory-wait handling
// and a sticky flag for misaligned redirect targets.
module fetch_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned INC      = 4,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic       reloj,
  input  logic       reset,
  fetch_pipe_if.slave bus
);

  localparam logic [WIDTH-1:0] RESET_PC_W = RESET_PC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

  // Word-align a redirect target by clearing the two byte-offset bits.
  function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

  logic [WIDTH-1:0] pc_p0;
  logic [WIDTH-1:0] pc_inc_p0;
  logic [WIDTH-1:0] target_p0;
  logic             redirect_p0;
  logic             advance_p0;
  logic             target_misaligned_p0;

  logic [31:0]      instr_p1;
  logic [WIDTH-1:0] pc4_p1;
  logic             vld_p1;
  logic             misalign_q;

  assign redirect_p0          = (bus.SEL_DIR != 2'b00);
  assign advance_p0           = ~bus.stall & bus.mem_ready;
  assign pc_inc_p0            = pc_p0 + INC_W;
  assign target_misaligned_p0 = (target_p0[1:0] != 2'b00);

  // Select the redirect target; sequential code yields zero and is unused.
  always_comb begin
    target_p0 = '0;
    unique case (bus.SEL_DIR)
      2'b01:   target_p0 = bus.DOA_exe;
      2'b10:   target_p0 = bus.jump_exe;
      2'b11:   target_p0 = bus.branch_exe;
      default: target_p0 = '0;
    endcase
  end

  // ---- stage 0: program counter (redirect beats stall and memory wait) ----
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC_W;
    end else if (redirect_p0) begin
      pc_p0 <= align_word(target_p0);
    end else if (advance_p0) begin
      pc_p0 <= pc_inc_p0;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (redirect_p0 && target_misaligned_p0) begin
      misalign_q <= 1'b1;
    end
  end

  // ---- stage 1: IF/ID register (squash, hold, capture or bubble) ----
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      instr_p1 <= NOP;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (redirect_p0 || bus.flush) begin
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end else if (bus.stall) begin
      instr_p1 <= instr_p1;
      vld_p1   <= vld_p1;
    end else if (bus.mem_ready) begin
      instr_p1 <= bus.INSTR;
      pc4_p1   <= pc_inc_p0;
      vld_p1   <= 1'b1;
    end else begin
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end
  end

  assign bus.OUT_REG1   = pc_p0;
  assign bus.PC_4       = pc_inc_p0[WIDTH-1:WIDTH-4];
  assign bus.IFID_instr = instr_p1;
  assign bus.IFID_pc4   = pc4_p1;
  assign bus.IFID_valid = vld_p1;
  assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: directed walk through the fetch scenarios followed by
// randomized traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_pipe;

  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned INC      = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic reloj;
  logic reset;

  fetch_pipe_if #(.WIDTH(WIDTH)) bus ();

  fetch_pipe #(
    .WIDTH(WIDTH), .RESET_PC(RESET_PC), .INC(INC), .NOP(NOP)
  ) dut (
    .reloj(reloj),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] add_mod(input logic [31:0] a, input int unsigned b);
    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
  endfunction

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = NOP;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] nxt;
    nxt = add_mod(m_pc, INC);
    chk({tag, ".OUT_REG1"},   bus.OUT_REG1, m_pc);
    chk({tag, ".PC_4"},       {28'h0, bus.PC_4}, {28'h0, nxt[31:28]});
    chk({tag, ".IFID_instr"}, bus.IFID_instr, m_instr);
    chk({tag, ".IFID_pc4"},   bus.IFID_pc4, m_pc4);
    chk({tag, ".IFID_valid"}, {31'h0, bus.IFID_valid}, {31'h0, m_valid});
    chk({tag, ".misalign"},   {31'h0, bus.misalign}, {31'h0, m_mis});
  endtask

  // One clock: drive at the falling edge, advance the model, check after the rising edge.
  task automatic cycle(input string tag, input logic [1:0] sel,
                       input logic [31:0] doa, input logic [31:0] jmp, input logic [31:0] br,
                       input logic st, input logic fl, input logic mr, input logic [31:0] ins);
    logic [31:0] tgt;
    logic [31:0] seq;
    bus.SEL_DIR    = sel;
    bus.DOA_exe    = doa;
    bus.jump_exe   = jmp;
    bus.branch_exe = br;
    bus.stall      = st;
    bus.flush      = fl;
    bus.mem_ready  = mr;
    bus.INSTR      = ins;
    seq = add_mod(m_pc, INC);
    case (sel)
      2'd1:    tgt = doa;
      2'd2:    tgt = jmp;
      2'd3:    tgt = br;
      default: tgt = 32'h0;
    endcase
    if (sel != 2'd0 || fl) begin
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (st) begin
      m_valid = m_valid;
    end else if (mr) begin
      m_instr = ins;
      m_pc4   = seq;
      m_valid = 1'b1;
    end else begin
      m_instr = NOP;
      m_valid = 1'b0;
    end
    if (sel != 2'd0) begin
      if (tgt % 4 != 0) m_mis = 1'b1;
      m_pc = tgt - (tgt % 4);
    end else if (!st && mr) begin
      m_pc = seq;
    end
    @(posedge reloj);
    #1;
    check_all(tag);
    @(negedge reloj);
  endtask

  task automatic seq_cycle(input string tag, input logic st, input logic fl, input logic mr);
    cycle(tag, 2'd0, 32'h0, 32'h0, 32'h0, st, fl, mr, $urandom);
  endtask

  initial begin
    reset = 1'b1;
    bus.SEL_DIR = 2'd0; bus.DOA_exe = '0; bus.jump_exe = '0; bus.branch_exe = '0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.mem_ready = 1'b0; bus.INSTR = '0;
    model_reset();
    @(negedge reloj);
    @(negedge reloj);
    chk("rst.OUT_REG1",   bus.OUT_REG1, 32'h0);
    chk("rst.PC_4",       {28'h0, bus.PC_4}, 32'h0);
    chk("rst.IFID_instr", bus.IFID_instr, NOP);
    chk("rst.IFID_pc4",   bus.IFID_pc4, 32'h0);
    chk("rst.IFID_valid", {31'h0, bus.IFID_valid}, 32'h0);
    chk("rst.misalign",   {31'h0, bus.misalign}, 32'h0);
    reset = 1'b0;

    // Sequential fetch with a two-cycle stall at PC=8
    seq_cycle("seq0", 1'b0, 1'b0, 1'b1);
    seq_cycle("seq1", 1'b0, 1'b0, 1'b1);
    chk("seq.pc_8",   bus.OUT_REG1, 32'h8);
    chk("seq.pc4_8",  bus.IFID_pc4, 32'h8);
    seq_cycle("stall0", 1'b1, 1'b0, 1'b1);
    seq_cycle("stall1", 1'b1, 1'b0, 1'b1);
    chk("stall.pc_hold",  bus.OUT_REG1, 32'h8);
    chk("stall.pc4_hold", bus.IFID_pc4, 32'h8);
    seq_cycle("resume0", 1'b0, 1'b0, 1'b1);
    chk("resume.pc_c", bus.OUT_REG1, 32'hC);
    seq_cycle("resume1", 1'b0, 1'b0, 1'b1);
    chk("resume.pc_10", bus.OUT_REG1, 32'h10);

    // Jump redirect while stalled
    cycle("jump", 2'd2, 32'h0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, $urandom);
    chk("jump.pc",    bus.OUT_REG1, 32'h100);
    chk("jump.valid", {31'h0, bus.IFID_valid}, 32'h0);
    seq_cycle("jump_tgt", 1'b0, 1'b0, 1'b1);
    chk("jump_tgt.pc4",   bus.IFID_pc4, 32'h104);
    chk("jump_tgt.valid", {31'h0, bus.IFID_valid}, 32'h1);

    // Memory wait at PC=0x20
    cycle("reg20", 2'd1, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom);
    seq_cycle("wait0", 1'b0, 1'b0, 1'b0);
    seq_cycle("wait1", 1'b0, 1'b0, 1'b0);
    seq_cycle("wait2", 1'b0, 1'b0, 1'b0);
    chk("wait.pc",    bus.OUT_REG1, 32'h20);
    chk("wait.instr", bus.IFID_instr, NOP);
    seq_cycle("wait_done", 1'b0, 1'b0, 1'b1);
    chk("wait_done.pc4", bus.IFID_pc4, 32'h24);

    // Misaligned branch target
    cycle("br42", 2'd3, 32'h0, 32'h0, 32'h0000_0042, 1'b0, 1'b0, 1'b1, $urandom);
    chk("br42.pc",  bus.OUT_REG1, 32'h40);
    chk("br42.mis", {31'h0, bus.misalign}, 32'h1);
    for (int i = 0; i < 3; i++) seq_cycle("mis_sticky", 1'b0, 1'b0, 1'b1);

    // Wrap-around through the top of the address space
    cycle("wrap_reg", 2'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom);
    chk("wrap.pc_top", bus.OUT_REG1, 32'hFFFF_FFFC);
    chk("wrap.pc_4",   {28'h0, bus.PC_4}, 32'h0);
    seq_cycle("wrap_seq", 1'b0, 1'b0, 1'b1);
    chk("wrap.pc_zero", bus.OUT_REG1, 32'h0);
    chk("wrap.pc4",     bus.IFID_pc4, 32'h0);

    // Flush alone, then flush together with stall
    seq_cycle("flush", 1'b0, 1'b1, 1'b1);
    chk("flush.pc",    bus.OUT_REG1, 32'h4);
    chk("flush.valid", {31'h0, bus.IFID_valid}, 32'h0);
    seq_cycle("seq_after_flush", 1'b0, 1'b0, 1'b1);
    seq_cycle("stall_flush", 1'b1, 1'b1, 1'b1);
    chk("stall_flush.pc", bus.OUT_REG1, 32'h8);

    // Asynchronous reset in the middle of a cycle
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst.OUT_REG1", bus.OUT_REG1, 32'h0);
    chk("arst.valid",    {31'h0, bus.IFID_valid}, 32'h0);
    chk("arst.pc4",      bus.IFID_pc4, 32'h0);
    chk("arst.instr",    bus.IFID_instr, NOP);
    chk("arst.misalign", {31'h0, bus.misalign}, 32'h0);
    @(negedge reloj);
    reset = 1'b0;
    seq_cycle("post_rst", 1'b0, 1'b0, 1'b1);
    chk("post_rst.pc4",   bus.IFID_pc4, 32'h4);
    chk("post_rst.valid", {31'h0, bus.IFID_valid}, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] sel;
      sel = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cycle("rand", sel, $urandom, $urandom, $urandom,
            ($urandom % 5 == 0), ($urandom % 10 == 0), ($urandom % 4 != 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pipe.md
# fetch_pipe

Parametrised instruction-fetch stage for the pipelined datapath. It holds the program counter and selects the next PC from four sources: sequential, register, jump and branch. It presents the PC to instruction memory and captures the returned instruction into an IF/ID pipeline register with a valid bit. It also adds stall, flush, memory-wait and misaligned-target handling.

## Interface
- WIDTH, 32: PC/address width in bits; legal range 8..32.
- RESET_PC, 0: PC value loaded on reset; must be a multiple of 4.
- INC, 4: sequential increment in bytes.
- NOP, 32'h0000_0000: instruction word inserted into IF/ID on a bubble.

Ports (clock and reset first):
- reloj  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- SEL_DIR  in  2  next-PC source: 00 sequential, 01 DOA_exe (register), 10 jump_exe, 11 branch_exe.
- DOA_exe  in  WIDTH  register-indirect target from execute.
- jump_exe  in  WIDTH  absolute jump target from execute.
- branch_exe  in  WIDTH  taken-branch target from execute.
- stall  in  1  hazard-unit stall; holds PC and IF/ID.
- flush  in  1  squashes IF/ID contents.
- mem_ready  in  1  INSTR is valid for the current OUT_REG1 this cycle.
- INSTR  in  32  instruction word from instruction memory.
- OUT_REG1  out  WIDTH  current PC, driven to instruction memory.
- PC_4  out  4  bits [WIDTH-1:WIDTH-4] of OUT_REG1+INC, used for jump concatenation.
- IFID_instr  out  32  registered instruction.
- IFID_pc4  out  WIDTH  registered OUT_REG1+INC of the captured instruction.
- IFID_valid  out  1  IF/ID holds a real instruction.
- misalign  out  1  sticky flag: a redirect target had a nonzero [1:0].

## Operation
- redirect = (SEL_DIR != 00). advance = ~stall & mem_ready.
- PC next-state priority:
  1. reset: PC = RESET_PC.
  2. redirect: PC = selected target with bits [1:0] forced to 0. Redirect overrides stall and mem_ready.
  3. advance: PC = PC + INC.
  4. Otherwise PC holds.
- PC arithmetic is modulo 2^WIDTH. With WIDTH=32, 32'hFFFF_FFFC + 4 = 0. No carry-out.
- misalign is set when a redirect target has [1:0] != 0. It stays set until reset.
- IF/ID update priority:
  1. reset: instr=NOP, pc4=0, valid=0.
  2. redirect or flush: instr=NOP, valid=0, pc4 holds.
  3. stall: all fields hold.
  4. mem_ready: instr=INSTR, pc4=PC+INC, valid=1.
  5. Otherwise (memory wait): instr=NOP, valid=0, pc4 holds.
- flush without redirect does not change the PC; the PC still follows the rules above.
- A SEL_DIR of 11 is a real branch source. It is not an unused code.

## Timing
- Reset values: OUT_REG1=RESET_PC, IFID_instr=NOP, IFID_pc4=0, IFID_valid=0, misalign=0. PC_4=top4(RESET_PC+INC).
- PC_4 is combinational from OUT_REG1 and is valid in the same cycle.
- Fetch latency is one cycle: INSTR sampled at edge N with mem_ready=1 appears on IFID_* after edge N.
- A redirect presented in cycle N:
  - sets OUT_REG1 = target after edge N;
  - produces IFID_valid=0 after edge N;
  - gives the first target instruction IFID_valid=1 after edge N+1, provided mem_ready=1 and no stall.
- Reset asserted mid-stream forces all outputs to their reset values without waiting for a clock edge. The first fetch from RESET_PC is captured at the first edge after reset deasserts.
- Simultaneous stall and flush: flush wins for IF/ID; the PC holds.

## Test plan
- Sequential fetch: reset, then mem_ready=1 and SEL_DIR=00 for 4 cycles. Expect:
  - OUT_REG1 = 0, 4, 8, C, 10;
  - IFID_pc4 = 4, 8, C, 10;
  - IFID_valid=1 from the first edge onward.
- Stall: at PC=8, assert stall for 2 cycles. Expect OUT_REG1 to hold at 8 and IFID to hold its contents; the sequence resumes to C one edge after release.
- Redirect overrides stall: stall=1, SEL_DIR=10, jump_exe=32'h0000_0100. Expect OUT_REG1=100 and IFID_valid=0 after one edge, then IFID_pc4=104 with IFID_valid=1.
- Memory wait: mem_ready=0 for 3 cycles at PC=20. Expect PC held at 20, IFID_instr=NOP and IFID_valid=0; after mem_ready=1, IFID_pc4=24.
- Misaligned branch: SEL_DIR=11, branch_exe=32'h0000_0042. Expect OUT_REG1=40 and misalign=1; misalign stays 1 until reset, which clears it asynchronously.
- Wrap and flush:
  - DOA_exe=32'hFFFF_FFFC via SEL_DIR=01, then sequential fetch. Expect OUT_REG1 to go FFFFFFFC then 0, with PC_4=4'h0.
  - flush=1 for one cycle. Expect IFID_valid=0 while the PC still advances.
